// File: rtl/ins_mem.sv
// Instruction memory responder: fetch requests return a registered word with a
// one-cycle en_ram_out pulse LATENCY cycles later; a load port writes the array.
module ins_mem #(
  parameter int AW      = 8,
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_ram_in,
  input  logic [15:0]   addr,
  output logic [15:0]   ins,
  output logic          en_ram_out,
  output logic          busy,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [15:0]   ld_data
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  localparam bit         DIRECT   = (LATENCY == 1);

  state_t        r_state, w_nxt;
  logic [3:0]    r_cnt;
  logic [15:0]   r_addr;
  logic [15:0]   r_rd;
  logic [15:0]   r_mem [2**AW];

  logic [15:0]   w_fa;
  logic [AW-1:0] w_idx;
  logic          w_oor;
  logic          w_hit;
  logic          w_enter;

  // With LATENCY=1 the read happens on the accepting edge, before r_addr holds it.
  assign w_fa    = (r_state == S_IDLE) ? addr : r_addr;
  assign w_idx   = w_fa[AW-1:0];
  assign w_oor   = |w_fa[15:AW];
  assign w_hit   = ld_en && (ld_addr == w_idx);
  assign w_enter = (w_nxt == S_RESP) && (r_state != S_RESP);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: if (en_ram_in) w_nxt = DIRECT ? S_RESP : S_WAIT;
      S_WAIT: if (r_cnt <= 4'd1) w_nxt = S_RESP;
      S_RESP: w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ld_en) r_mem[ld_addr] <= ld_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_addr     <= 16'h0000;
      r_rd       <= 16'h0000;
      ins        <= 16'h0000;
      en_ram_out <= 1'b0;
      busy       <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (r_state == S_IDLE && en_ram_in) begin
        r_addr <= addr;
        r_cnt  <= CNT_INIT;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // Snapshot taken on the RESP-entry edge, with write-through from the load port.
      if (w_enter) r_rd <= w_oor ? 16'h0000 : (w_hit ? ld_data : r_mem[w_idx]);
      if (r_state == S_RESP) ins <= r_rd;
      en_ram_out <= (r_state == S_RESP);
      busy       <= (w_nxt != S_IDLE) || (r_state == S_RESP);
    end
  end

endmodule
